alu_sequencer: RTL and testbench
================================

# alu_sequencer

Fetch/decode/writeback controller that drives the opcode-based ALU from the other side of its interface. It holds a 16-entry instruction memory and a 4-entry register file, and issues opcode, operands, immediate and carry-in to the combinational ALU. It captures the ALU's result and flags and writes the result back. It sits between the program loader/test harness and the ALU.

## Interface
- data_size, 32, operand/result width
- iptr_size, 4, instruction address width (16 words)
- clkout  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution at pc=0 (sampled in IDLE/HALT only)
- prog_we  in  1  instruction memory write strobe (honoured only when busy=0)
- prog_addr  in  iptr_size  instruction memory write address
- prog_data  in  32  instruction word
- alu_opcode  out  8  opcode to ALU
- alu_A  out  data_size  R0 (accumulator) value
- alu_B  out  data_size  Rn value
- alu_val  out  data_size  sign-extended immediate
- alu_cin  out  1  latched carry (flags_q[3])
- alu_fl  out  1  latched zero flag (flags_q[4])
- alu_result  in  data_size  ALU result
- alu_flags  in  5  ALU flags [Z C S P V]
- busy  out  1  high in FETCH/DECODE/EXEC/WB
- halted  out  1  high in HALT
- err  out  1  sticky: illegal opcode seen since last start
- pc_out  out  iptr_size  current pc
- acc_out  out  data_size  R0

## Operation
- Instruction word: [31:24] opcode, [23:22] rn, [21:16] unused, [15:0] imm (sign-extended to data_size).
- ALU opcodes 29–44 (ADA, ADI, SBA, SBI, ACA, ACI, SCA, SCI, ANA, ANI, ORA, ORI, XRA, XRI, XNA, XNI): register forms (odd codes 29..43) write R0; immediate forms (even codes 30..44) write Rn.
- Control opcodes: 0x00 NOP; 0x01 JUD (pc=imm[3:0]); 0x02 JCD (pc=imm[3:0] if flags_q[4]=1, else pc+1); 0xFF HLT.
- Any other opcode executes as NOP and sets err.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE/HALT -> FETCH on start. On this transition pc=0, err=0. R0–R3 and flags_q are retained.
  - FETCH -> DECODE: IR <= imem[pc].
  - DECODE -> EXEC: register alu_opcode, alu_A, alu_B and alu_val from IR and the register file.
  - EXEC -> WB: capture alu_result into res_q. For ALU opcodes only, capture alu_flags into flags_q.
  - WB: write res_q to the destination register (ALU opcodes only) and update pc.
  - WB -> HALT if HLT, else WB -> FETCH.
- Outside DECODE..EXEC, alu_opcode=0x00. The ALU ignores this code, so its result holds.
- pc increments modulo 16 (15 -> 0).
- prog_we is ignored while busy=1. start is ignored while busy=1.

## Timing
- Every instruction takes exactly 4 clkout edges, FETCH through WB.
- The edge that samples start puts the FSM in FETCH. The next instruction's FETCH begins 4 edges after the previous one.
- ALU outputs are registered and stable for the full EXEC cycle. The ALU has one full cycle to settle before the capture at the EXEC->WB edge.
- Register writeback is visible to the DECODE of the next instruction. No hazards exist.
- Reset (asynchronous, any state) forces:
  - state=IDLE, pc=0, IR=0, R0–R3=0, flags_q=0, res_q=0, err=0
  - all ALU-side outputs=0, busy=0, halted=0
- Imem contents are not reset.
- Reset asserted mid-instruction discards that instruction: no writeback, no pc update.
- prog_we and start in the same IDLE cycle: the write takes effect, and the FETCH on the following cycle reads the new word if it is at address 0.

## Test plan
- Basic program:
  - Stimulus: load 0x1E400005 (ADI R1,#5), 0x1D400000 (ADA R0,R1), 0xFF000000 (HLT), then pulse start.
  - Response: halted=1 exactly 12 edges after start is sampled, R1=5, acc_out=5, pc_out=2, err=0.
- Immediate sign extension:
  - Stimulus: ADI R2,#0xFFFF (0x1E80FFFF) from reset.
  - Response: R2=0xFFFFFFFF. alu_val=0xFFFFFFFF observed during EXEC.
- Carry chain:
  - Stimulus: with a bench ALU model returning flags[3]=1 for an SBI, follow it with ACA.
  - Response: alu_cin=1 throughout the ACA's DECODE/EXEC. flags_q is unchanged across an intervening NOP.
- Conditional jump and wrap:
  - Stimulus: XRA R0,R0 (Z=1), then JCD #5.
  - Response: next FETCH is at pc=5.
  - Stimulus: same with Z=0.
  - Response: next FETCH is at pc+1. An instruction at address 15 falls through to address 0.
- Illegal opcode and gating:
  - Stimulus: opcode 0x50. Also drive prog_we=1 and start=1 while busy.
  - Response: err=1 and no register change. The imem word and the running program are unaffected.
- Async reset mid-EXEC of an ADA:
  - Response: outputs drop to reset values without waiting for a clock edge. R0 is not written. A new start executes from pc=0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ALU-side bus of the sequencer: operands/opcode towards the ALU,
// result and flags back from it.
interface alu_sequencer_if #(
    parameter int unsigned data_size = 32
);
    logic [7:0]           alu_opcode;
    logic [data_size-1:0] alu_A;
    logic [data_size-1:0] alu_B;
    logic [data_size-1:0] alu_val;
    logic                 alu_cin;
    logic                 alu_fl;
    logic [data_size-1:0] alu_result;
    logic [4:0]           alu_flags;

    modport master (
        output alu_opcode, alu_A, alu_B, alu_val, alu_cin, alu_fl,
        input  alu_result, alu_flags
    );

    modport slave (
        input  alu_opcode, alu_A, alu_B, alu_val, alu_cin, alu_fl,
        output alu_result, alu_flags
    );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/writeback controller for the opcode-based ALU.
// 16-word instruction memory, 4-entry register file (R0 = accumulator),
// four-cycle FETCH/DECODE/EXEC/WB instruction sequence.
module alu_sequencer #(
    parameter int unsigned data_size = 32,
    parameter int unsigned iptr_size = 4
) (
    input  logic                 clkout,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [iptr_size-1:0] prog_addr,
    input  logic [31:0]          prog_data,
    alu_sequencer_if.master      alu,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [iptr_size-1:0] pc_out,
    output logic [data_size-1:0] acc_out
);

    localparam logic [2:0] st_idle   = 3'd0;
    localparam logic [2:0] st_fetch  = 3'd1;
    localparam logic [2:0] st_decode = 3'd2;
    localparam logic [2:0] st_exec   = 3'd3;
    localparam logic [2:0] st_wb     = 3'd4;
    localparam logic [2:0] st_halt   = 3'd5;

    localparam logic [7:0] op_nop = 8'h00;
    localparam logic [7:0] op_jud = 8'h01;
    localparam logic [7:0] op_jcd = 8'h02;
    localparam logic [7:0] op_hlt = 8'hFF;
    localparam logic [7:0] op_ada = 8'd29;
    localparam logic [7:0] op_xni = 8'd44;

    localparam logic [iptr_size-1:0] pc_one = iptr_size'(1);

    logic [2:0]           state;
    logic [iptr_size-1:0] pc;
    logic [7:0]           ir_op;
    logic [1:0]           ir_rn;
    logic [15:0]          ir_imm;
    logic [data_size-1:0] regs [4];
    logic [4:0]           flags_q;
    logic [data_size-1:0] res_q;
    logic                 err_q;
    logic [7:0]           opcode_q;
    logic [data_size-1:0] a_q;
    logic [data_size-1:0] b_q;
    logic [data_size-1:0] val_q;

    logic [31:0]          imem [2**iptr_size];

    logic                 is_alu;
    logic                 is_illegal;
    logic [1:0]           dest;
    logic [data_size-1:0] imm_ext;
    logic [iptr_size-1:0] next_pc;

    // Decode of the held instruction register and next-pc selection
    always_comb begin
        is_alu     = (ir_op >= op_ada) && (ir_op <= op_xni);
        is_illegal = !is_alu && (ir_op != op_nop) && (ir_op != op_jud) &&
                     (ir_op != op_jcd) && (ir_op != op_hlt);
        // odd ALU codes are register forms and target the accumulator
        dest       = ir_op[0] ? 2'd0 : ir_rn;
        imm_ext    = {{(data_size-16){ir_imm[15]}}, ir_imm};
        next_pc    = pc + pc_one;
        if (ir_op == op_jud) begin
            next_pc = ir_imm[iptr_size-1:0];
        end else if (ir_op == op_jcd && flags_q[4]) begin
            next_pc = ir_imm[iptr_size-1:0];
        end else if (ir_op == op_hlt) begin
            next_pc = pc;
        end
    end

    // Instruction memory load port, blocked while a program is running
    always_ff @(posedge clkout) begin
        if (prog_we && !busy) begin
            imem[prog_addr] <= prog_data;
        end
    end

    // Sequencer FSM, register file, flags and ALU-side output registers
    always_ff @(posedge clkout or negedge rst_n) begin
        if (!rst_n) begin
            state    <= st_idle;
            pc       <= '0;
            ir_op    <= '0;
            ir_rn    <= '0;
            ir_imm   <= '0;
            flags_q  <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            opcode_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            val_q    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                st_idle, st_halt: begin
                    if (start) begin
                        state <= st_fetch;
                        pc    <= '0;
                        err_q <= 1'b0;
                    end
                end
                st_fetch: begin
                    ir_op  <= imem[pc][31:24];
                    ir_rn  <= imem[pc][23:22];
                    ir_imm <= imem[pc][15:0];
                    state  <= st_decode;
                end
                st_decode: begin
                    opcode_q <= ir_op;
                    a_q      <= regs[0];
                    b_q      <= regs[ir_rn];
                    val_q    <= imm_ext;
                    state    <= st_exec;
                end
                st_exec: begin
                    res_q <= alu.alu_result;
                    if (is_alu) begin
                        flags_q <= alu.alu_flags;
                    end
                    opcode_q <= '0;
                    state    <= st_wb;
                end
                st_wb: begin
                    if (is_alu) begin
                        regs[dest] <= res_q;
                    end
                    if (is_illegal) begin
                        err_q <= 1'b1;
                    end
                    pc    <= next_pc;
                    state <= (ir_op == op_hlt) ? st_halt : st_fetch;
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign alu.alu_opcode = opcode_q;
    assign alu.alu_A      = a_q;
    assign alu.alu_B      = b_q;
    assign alu.alu_val    = val_q;
    assign alu.alu_cin    = flags_q[3];
    assign alu.alu_fl     = flags_q[4];

    assign busy    = (state == st_fetch) || (state == st_decode) ||
                     (state == st_exec)  || (state == st_wb);
    assign halted  = (state == st_halt);
    assign err     = err_q;
    assign pc_out  = pc;
    assign acc_out = regs[0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a reference ALU answers the sequencer, and every
// ALU issue (opcode, A, B, imm, cin, fl) is scored against an expected queue.
module tb_alu_sequencer;

    logic        clkout;
    logic        rst_n;
    logic        start;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [31:0] prog_data;
    logic        busy;
    logic        halted;
    logic        err;
    logic [3:0]  pc_out;
    logic [31:0] acc_out;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
        logic        cin;
        logic        fl;
    } issue_t;

    issue_t exp_q[$];

    alu_sequencer_if #(.data_size(32)) bus ();

    alu_sequencer #(.data_size(32), .iptr_size(4)) dut (
        .clkout   (clkout),
        .rst_n    (rst_n),
        .start    (start),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .alu      (bus),
        .busy     (busy),
        .halted   (halted),
        .err      (err),
        .pc_out   (pc_out),
        .acc_out  (acc_out)
    );

    initial begin
        clkout = 1'b0;
        forever #5 clkout = ~clkout;
    end

    // Reference ALU: register forms use A,B; immediate forms use Rn (B) and imm
    logic [32:0] w;
    always_comb begin
        w = '0;
        case (bus.alu_opcode)
            8'd29: w = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
            8'd30: w = {1'b0, bus.alu_B} + {1'b0, bus.alu_val};
            8'd31: w = {1'b0, bus.alu_A} - {1'b0, bus.alu_B};
            8'd32: w = {1'b0, bus.alu_B} - {1'b0, bus.alu_val};
            8'd33: w = {1'b0, bus.alu_A} + {1'b0, bus.alu_B} + {32'd0, bus.alu_cin};
            8'd34: w = {1'b0, bus.alu_B} + {1'b0, bus.alu_val} + {32'd0, bus.alu_cin};
            8'd35: w = {1'b0, bus.alu_A} - {1'b0, bus.alu_B} - {32'd0, bus.alu_cin};
            8'd36: w = {1'b0, bus.alu_B} - {1'b0, bus.alu_val} - {32'd0, bus.alu_cin};
            8'd37: w = {1'b0, bus.alu_A & bus.alu_B};
            8'd38: w = {1'b0, bus.alu_B & bus.alu_val};
            8'd39: w = {1'b0, bus.alu_A | bus.alu_B};
            8'd40: w = {1'b0, bus.alu_B | bus.alu_val};
            8'd41: w = {1'b0, bus.alu_A ^ bus.alu_B};
            8'd42: w = {1'b0, bus.alu_B ^ bus.alu_val};
            8'd43: w = {1'b0, ~(bus.alu_A ^ bus.alu_B)};
            8'd44: w = {1'b0, ~(bus.alu_B ^ bus.alu_val)};
            default: w = '0;
        endcase
        bus.alu_result = w[31:0];
        bus.alu_flags  = {(w[31:0] == 32'd0), w[32], w[31], ^w[31:0], 1'b0};
    end

    // Scoreboard: each ALU issue seen during EXEC pops one expected entry
    always @(negedge clkout) begin
        if (rst_n && bus.alu_opcode >= 8'd29 && bus.alu_opcode <= 8'd44) begin
            issue_t obs;
            obs = '{bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_val, bus.alu_cin, bus.alu_fl};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected got op=%0d A=%h B=%h val=%h cin=%b fl=%b, expected none",
                         obs.op, obs.a, obs.b, obs.val, obs.cin, obs.fl);
            end else begin
                issue_t e;
                e = exp_q.pop_front();
                if (obs !== e) begin
                    miscompares++;
                    $display("FAIL issue got op=%0d A=%h B=%h val=%h cin=%b fl=%b, expected op=%0d A=%h B=%h val=%h cin=%b fl=%b",
                             obs.op, obs.a, obs.b, obs.val, obs.cin, obs.fl,
                             e.op, e.a, e.b, e.val, e.cin, e.fl);
                end
            end
        end
    end

    task automatic push(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] val, input logic cin, input logic fl);
        exp_q.push_back('{op, a, b, val, cin, fl});
    endtask

    task automatic load_word(input logic [3:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clkout); #1;
        prog_we   = 1'b0;
    endtask

    // Pulses start; the edge that samples it is edge 0
    task automatic start_run();
        start = 1'b1;
        @(posedge clkout); #1;
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    // Counts edges after the start edge until halted; inject_at>0 drives
    // prog_we/start for two cycles from that edge on
    task automatic wait_halt(input int inject_at, output int edges);
        edges = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clkout); #1;
            if (inject_at > 0 && n == inject_at) begin
                prog_we = 1'b1; prog_addr = 4'd2; prog_data = 32'h0; start = 1'b1;
            end
            if (inject_at > 0 && n == inject_at + 2) begin
                prog_we = 1'b0; start = 1'b0;
            end
            if (halted) begin
                edges = n;
                break;
            end
        end
        prog_we = 1'b0;
        start   = 1'b0;
        if (edges == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL halt_timeout halted=%b after 100 edges, expected 1", halted);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clkout);
        #1;
        vectors++;
        if ({busy, halted, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status got busy/halted/err=%b, expected 000", {busy, halted, err});
        end
        vectors++;
        if ({pc_out, acc_out} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_regs got pc=%0d acc=%h, expected 0/0", pc_out, acc_out);
        end
        vectors++;
        if ({bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_val, bus.alu_cin, bus.alu_fl} !== '0) begin
            miscompares++;
            $display("FAIL reset_alu got op=%h A=%h B=%h val=%h cin=%b fl=%b, expected all 0",
                     bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_val, bus.alu_cin, bus.alu_fl);
        end
        rst_n = 1'b1;
        @(posedge clkout); #1;
    endtask

    task automatic test_basic();
        int edges;
        load_word(4'd0, 32'h1E400005);
        load_word(4'd1, 32'h1D400000);
        load_word(4'd2, 32'hFF000000);
        push(8'd30, 32'h0, 32'h0, 32'h5, 1'b0, 1'b0);
        push(8'd29, 32'h0, 32'h5, 32'h0, 1'b0, 1'b0);
        start_run();
        wait_halt(0, edges);
        vectors++;
        if (edges !== 12) begin
            miscompares++;
            $display("FAIL basic_latency got %0d edges, expected 12", edges);
        end
        vectors++;
        if (acc_out !== 32'h5) begin
            miscompares++;
            $display("FAIL basic_acc got %h, expected 00000005", acc_out);
        end
        vectors++;
        if ({pc_out, err} !== {4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_pc_err got pc=%0d err=%b, expected pc=2 err=0", pc_out, err);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_sign_ext();
        int edges;
        rst_n = 1'b0;
        @(posedge clkout); #1;
        rst_n = 1'b1;
        load_word(4'd0, 32'h1E80FFFF);
        load_word(4'd1, 32'h1D800000);
        load_word(4'd2, 32'hFF000000);
        push(8'd30, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0);
        push(8'd29, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        start_run();
        wait_halt(0, edges);
        vectors++;
        if (acc_out !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL sext_acc got %h, expected ffffffff", acc_out);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sext_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_carry_chain();
        int edges;
        load_word(4'd0, 32'h20400001);
        load_word(4'd1, 32'h00000000);
        load_word(4'd2, 32'h21400000);
        load_word(4'd3, 32'hFF000000);
        push(8'd32, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0);
        push(8'd33, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        start_run();
        wait_halt(0, edges);
        vectors++;
        if ({acc_out, bus.alu_cin} !== {32'hFFFFFFFF, 1'b1}) begin
            miscompares++;
            $display("FAIL carry_result got acc=%h cin=%b, expected ffffffff/1", acc_out, bus.alu_cin);
        end
        vectors++;
        if (edges !== 16) begin
            miscompares++;
            $display("FAIL carry_latency got %0d edges, expected 16", edges);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL carry_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_jcd_taken();
        int edges;
        load_word(4'd0, 32'h29000000);
        load_word(4'd1, 32'h02000005);
        load_word(4'd2, 32'hFF000000);
        load_word(4'd5, 32'hFF000000);
        push(8'd41, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        start_run();
        wait_halt(0, edges);
        vectors++;
        if ({pc_out, bus.alu_fl} !== {4'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL jcd_taken got pc=%0d fl=%b, expected pc=5 fl=1", pc_out, bus.alu_fl);
        end
        vectors++;
        if (edges !== 12) begin
            miscompares++;
            $display("FAIL jcd_taken_latency got %0d edges, expected 12", edges);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL jcd_taken_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_jcd_wrap();
        int edges;
        load_word(4'd0, 32'h0200000F);
        load_word(4'd1, 32'hFF000000);
        load_word(4'd15, 32'h28C00001);
        push(8'd40, 32'h0, 32'h0, 32'h1, 1'b0, 1'b1);
        start_run();
        wait_halt(0, edges);
        vectors++;
        if (pc_out !== 4'd1) begin
            miscompares++;
            $display("FAIL wrap_not_taken got pc=%0d, expected 1", pc_out);
        end
        vectors++;
        if (edges !== 16) begin
            miscompares++;
            $display("FAIL wrap_latency got %0d edges, expected 16", edges);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL wrap_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_illegal_gating();
        int edges;
        load_word(4'd0, 32'h50400007);
        load_word(4'd1, 32'h1D400000);
        load_word(4'd2, 32'hFF000000);
        push(8'd29, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        start_run();
        wait_halt(5, edges);
        vectors++;
        if ({err, pc_out} !== {1'b1, 4'd2}) begin
            miscompares++;
            $display("FAIL illegal_err got err=%b pc=%0d, expected err=1 pc=2", err, pc_out);
        end
        vectors++;
        if ({edges, acc_out} !== {32'd12, 32'hFFFFFFFF}) begin
            miscompares++;
            $display("FAIL illegal_gating got edges=%0d acc=%h, expected 12/ffffffff", edges, acc_out);
        end
        load_word(4'd0, 32'h00000000);
        push(8'd29, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        start_run();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear_on_start got %b, expected 0", err);
        end
        wait_halt(0, edges);
        vectors++;
        if ({edges, pc_out, acc_out, err} !== {32'd12, 4'd2, 32'hFFFFFFFE, 1'b0}) begin
            miscompares++;
            $display("FAIL imem_unaffected got edges=%0d pc=%0d acc=%h err=%b, expected 12/2/fffffffe/0",
                     edges, pc_out, acc_out, err);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL illegal_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_exec();
        int edges;
        load_word(4'd0, 32'h1D400000);
        load_word(4'd1, 32'hFF000000);
        push(8'd29, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        start_run();
        repeat (2) @(posedge clkout);
        @(negedge clkout); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, halted, err, pc_out, acc_out} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_status got busy=%b halted=%b err=%b pc=%0d acc=%h, expected all 0",
                     busy, halted, err, pc_out, acc_out);
        end
        vectors++;
        if ({bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_cin} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_alu got op=%h A=%h B=%h cin=%b, expected all 0",
                     bus.alu_opcode, bus.alu_A, bus.alu_B, bus.alu_cin);
        end
        @(posedge clkout); #1;
        rst_n = 1'b1;
        load_word(4'd1, 32'h1D400000);
        load_word(4'd2, 32'hFF000000);
        push(8'd30, 32'h0, 32'h0, 32'h3, 1'b0, 1'b0);
        push(8'd29, 32'h0, 32'h3, 32'h0, 1'b0, 1'b0);
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 32'h1E400003;
        start_run();
        wait_halt(0, edges);
        vectors++;
        if ({edges, pc_out, acc_out} !== {32'd12, 4'd2, 32'h3}) begin
            miscompares++;
            $display("FAIL restart_after_reset got edges=%0d pc=%0d acc=%h, expected 12/2/00000003",
                     edges, pc_out, acc_out);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_issues got %0d unconsumed, expected 0", exp_q.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        start       = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        test_reset();
        test_basic();
        test_sign_ext();
        test_carry_chain();
        test_jcd_taken();
        test_jcd_wrap();
        test_illegal_gating();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
